// File: rtl/vga_sync_gen_pkg.sv
// ============================================================================
// Package     : vga_timing_pkg
// Description : 640x480@60 raster timing constants shared by the sync
//               generator and the downstream colour generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    // Pixel clock divider: 50 MHz board clock -> 25 MHz pixel rate
    localparam int c_clk_div = 2;

    // Horizontal timing, in pixels
    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

    // Vertical timing, in lines
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    // Sync windows, inclusive coordinates
    localparam int c_h_sync_start = c_h_active + c_h_fp;
    localparam int c_h_sync_end   = c_h_sync_start + c_h_sync - 1;
    localparam int c_v_sync_start = c_v_active + c_v_fp;
    localparam int c_v_sync_end   = c_v_sync_start + c_v_sync - 1;

    // Both 640x480 syncs are active-low
    localparam logic c_hs_pol = 1'b0;
    localparam logic c_vs_pol = 1'b0;

    // Coordinate width; holds c_h_total-1 and c_v_total-1
    localparam int c_cw = 10;

    // Inclusive range test used for sync windows
    function automatic logic in_window(input logic [31:0] value,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_gen_axis_counter.sv
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis (horizontal or vertical). Holds the position
//               counter and decodes sync/active for the position it will hold
//               after the current edge, so the parent can register aligned
//               outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   TOTAL  = c_h_total,
    parameter int   ACTIVE = c_h_active,
    parameter int   FP     = c_h_fp,
    parameter int   SYNC   = c_h_sync,
    parameter logic POL    = c_hs_pol,
    parameter int   CW     = c_cw
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          iEn,
    output logic [CW-1:0] oCount,
    output logic [CW-1:0] oNextCount,
    output logic          oWrap,
    output logic          oSync,
    output logic          oActive
);

    localparam logic [CW-1:0] c_last   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] c_active = CW'(ACTIVE);
    localparam int            c_sync_lo = ACTIVE + FP;
    localparam int            c_sync_hi = ACTIVE + FP + SYNC - 1;

    logic [CW-1:0] r_count;

    // Next position and the decodes that describe it
    always_comb begin
        oWrap      = (r_count == c_last);
        oNextCount = r_count;
        if (iEn) begin
            oNextCount = oWrap ? '0 : r_count + CW'(1);
        end
        oActive = (oNextCount < c_active);
        oSync   = in_window(32'(oNextCount), 32'(c_sync_lo), 32'(c_sync_hi)) ? POL : ~POL;
    end

    // Position register; parks on the last position so the first enable lands on 0
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count <= c_last;
        end else begin
            r_count <= oNextCount;
        end
    end

    assign oCount = r_count;

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing generator. Divides the board clock into a
//               pixel tick, runs horizontal/vertical counters and drives
//               registered, mutually aligned sync, coordinate and blanking
//               outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = c_clk_div,
    parameter int   H_ACTIVE = c_h_active,
    parameter int   H_FP     = c_h_fp,
    parameter int   H_SYNC   = c_h_sync,
    parameter int   H_BP     = c_h_bp,
    parameter int   V_ACTIVE = c_v_active,
    parameter int   V_FP     = c_v_fp,
    parameter int   V_SYNC   = c_v_sync,
    parameter int   V_BP     = c_v_bp,
    parameter logic HS_POL   = c_hs_pol,
    parameter logic VS_POL   = c_vs_pol,
    parameter int   CW       = c_cw
) (
    input  logic          Clock,
    input  logic          Reset,
    output logic          oHSync,
    output logic          oVSync,
    output logic [CW-1:0] oCol,
    output logic [CW-1:0] oRow,
    output logic          oVideoOn,
    output logic          oPixelTick,
    output logic          oFrameStart
);

    localparam int c_h_tot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_tot = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic          w_tick;
    logic          w_v_en;
    logic [CW-1:0] w_h_count;
    logic [CW-1:0] w_h_next;
    logic          w_h_wrap;
    logic          w_h_sync;
    logic          w_h_active;
    logic [CW-1:0] w_v_count;
    logic [CW-1:0] w_v_next;
    logic          w_v_wrap;
    logic          w_v_sync;
    logic          w_v_active;
    logic          w_unused;

    generate
        if (CLK_DIV == 1) begin : g_div_bypass
            assign w_tick = 1'b1;
        end else begin : g_div_count
            localparam int              c_dw       = $clog2(CLK_DIV);
            localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);

            logic [c_dw-1:0] r_div;

            // Pixel divider; the tick is the edge on which it wraps back to 0
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    r_div <= '0;
                end else if (w_tick) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + c_dw'(1);
                end
            end

            assign w_tick = (r_div == c_div_last);
        end
    endgenerate

    // Vertical axis only advances when the line wraps
    assign w_v_en = w_tick & w_h_wrap;

    vga_axis_counter #(
        .TOTAL  (c_h_tot),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .POL    (HS_POL),
        .CW     (CW)
    ) u_h_axis (
        .Clock      (Clock),
        .Reset      (Reset),
        .iEn        (w_tick),
        .oCount     (w_h_count),
        .oNextCount (w_h_next),
        .oWrap      (w_h_wrap),
        .oSync      (w_h_sync),
        .oActive    (w_h_active)
    );

    vga_axis_counter #(
        .TOTAL  (c_v_tot),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .POL    (VS_POL),
        .CW     (CW)
    ) u_v_axis (
        .Clock      (Clock),
        .Reset      (Reset),
        .iEn        (w_v_en),
        .oCount     (w_v_count),
        .oNextCount (w_v_next),
        .oWrap      (w_v_wrap),
        .oSync      (w_v_sync),
        .oActive    (w_v_active)
    );

    // Current positions are only needed internally by the axis counters
    assign w_unused = ^{w_h_count, w_v_count};

    // Output registers load from next-state decodes on the tick, giving zero skew
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oHSync      <= ~HS_POL;
            oVSync      <= ~VS_POL;
            oCol        <= '0;
            oRow        <= '0;
            oVideoOn    <= 1'b0;
            oPixelTick  <= 1'b0;
            oFrameStart <= 1'b0;
        end else if (w_tick) begin
            oHSync      <= w_h_sync;
            oVSync      <= w_v_sync;
            oCol        <= w_h_next;
            oRow        <= w_v_next;
            oVideoOn    <= w_h_active & w_v_active;
            oPixelTick  <= 1'b1;
            oFrameStart <= w_h_wrap & w_v_wrap;
        end else begin
            oPixelTick  <= 1'b0;
            oFrameStart <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Directed self-checking bench for vga_sync_gen. Three
//               instances: default 640x480 timing, default vertical timing
//               with a short line and no divider, and a tiny raster with
//               active-high syncs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    // Default instance
    logic       b_hs, b_vs, b_von, b_tick, b_fs;
    logic [9:0] b_col, b_row;
    // Short-line instance, default vertical timing
    logic       v_hs, v_vs, v_von, v_tick, v_fs;
    logic [9:0] v_col, v_row;
    // Tiny instance, active-high syncs
    logic       t_hs, t_vs, t_von, t_tick, t_fs;
    logic [9:0] t_col, t_row;

    // Scan accumulators
    int   n_ticks, n_odd, n_low, lo_min, lo_max, n_fs, fs_at, n_bad, n_wrap, n_hi_h, n_hi_v;
    logic von_a, von_b, von_c, von_d, von_e;
    logic [9:0] row_at_last;
    logic prev_vs;
    logic [9:0] prev_col;
    logic found;

    always #5 clk = ~clk;

    vga_sync_gen u_big (
        .Clock       (clk),
        .Reset       (rst),
        .oHSync      (b_hs),
        .oVSync      (b_vs),
        .oCol        (b_col),
        .oRow        (b_row),
        .oVideoOn    (b_von),
        .oPixelTick  (b_tick),
        .oFrameStart (b_fs)
    );

    vga_sync_gen #(
        .CLK_DIV (1), .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1)
    ) u_vert (
        .Clock       (clk),
        .Reset       (rst),
        .oHSync      (v_hs),
        .oVSync      (v_vs),
        .oCol        (v_col),
        .oRow        (v_row),
        .oVideoOn    (v_von),
        .oPixelTick  (v_tick),
        .oFrameStart (v_fs)
    );

    vga_sync_gen #(
        .CLK_DIV (1), .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1)
    ) u_tiny (
        .Clock       (clk),
        .Reset       (rst),
        .oHSync      (t_hs),
        .oVSync      (t_vs),
        .oCol        (t_col),
        .oRow        (t_row),
        .oVideoOn    (t_von),
        .oPixelTick  (t_tick),
        .oFrameStart (t_fs)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- Scenario 1: reset and first tick ----------------
        rst = 1'b1;
        step(5);
        check("big_rst_hs",   32'(b_hs),   1);
        check("big_rst_vs",   32'(b_vs),   1);
        check("big_rst_von",  32'(b_von),  0);
        check("big_rst_col",  32'(b_col),  0);
        check("big_rst_row",  32'(b_row),  0);
        check("big_rst_tick", 32'(b_tick), 0);
        check("big_rst_fs",   32'(b_fs),   0);
        check("tiny_rst_hs",  32'(t_hs),   0);
        check("tiny_rst_vs",  32'(t_vs),   0);
        rst = 1'b0;
        step(1);
        check("big_gap_tick",   32'(b_tick), 0);
        check("big_gap_von",    32'(b_von),  0);
        check("tiny_first_tick", 32'(t_tick), 1);
        check("tiny_first_fs",   32'(t_fs),   1);
        step(1);
        check("big_first_tick", 32'(b_tick), 1);
        check("big_first_fs",   32'(b_fs),   1);
        check("big_first_col",  32'(b_col),  0);
        check("big_first_row",  32'(b_row),  0);
        check("big_first_von",  32'(b_von),  1);
        check("big_first_hs",   32'(b_hs),   1);
        check("big_first_vs",   32'(b_vs),   1);

        // ---------------- Scenario 2/4: one full line on default timing ----------------
        n_ticks = 0; n_odd = 0; n_low = 0; lo_min = 1023; lo_max = 0;
        von_a = 1'bx; von_b = 1'bx; row_at_last = 'x;
        for (int i = 1; i <= 1600; i++) begin
            step(1);
            if (b_tick) begin
                n_ticks++;
                if ((i % 2) != 0) n_odd++;
                if (!b_hs) begin
                    n_low++;
                    if (int'(b_col) < lo_min) lo_min = int'(b_col);
                    if (int'(b_col) > lo_max) lo_max = int'(b_col);
                end
                if (b_col == 10'd639) von_a = b_von;
                if (b_col == 10'd640) von_b = b_von;
                if (b_col == 10'd799) row_at_last = b_row;
            end
        end
        check("line_ticks",     32'(n_ticks), 800);
        check("line_odd_ticks", 32'(n_odd),   0);
        check("line_hs_low",    32'(n_low),   96);
        check("line_hs_first",  32'(lo_min),  656);
        check("line_hs_last",   32'(lo_max),  751);
        check("von_639_0",      32'(von_a),   1);
        check("von_640_0",      32'(von_b),   0);
        check("row_at_799",     32'(row_at_last), 0);
        check("line_end_col",   32'(b_col),   0);
        check("line_end_row",   32'(b_row),   1);
        check("line_end_fs",    32'(b_fs),    0);

        // ---------------- Scenario 5a: reset mid-line, colliding with a tick ----------------
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1);
            if (b_tick && b_col == 10'd100) found = 1'b1;
        end
        check("big_seek_col100", 32'(found), 1);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("big_mid_hs",   32'(b_hs),   1);
        check("big_mid_vs",   32'(b_vs),   1);
        check("big_mid_col",  32'(b_col),  0);
        check("big_mid_row",  32'(b_row),  0);
        check("big_mid_von",  32'(b_von),  0);
        check("big_mid_tick", 32'(b_tick), 0);
        check("big_mid_fs",   32'(b_fs),   0);
        step(1);
        check("big_re_gap_tick", 32'(b_tick), 0);
        step(1);
        check("big_re_tick", 32'(b_tick), 1);
        check("big_re_fs",   32'(b_fs),   1);
        check("big_re_col",  32'(b_col),  0);
        check("big_re_row",  32'(b_row),  0);
        check("big_re_von",  32'(b_von),  1);

        // ---------------- Scenario 3/4: full frame, default vertical timing ----------------
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        check("vert_first_fs",  32'(v_fs),  1);
        check("vert_first_row", 32'(v_row), 0);
        n_low = 0; lo_min = 1023; lo_max = 0; n_fs = 0; fs_at = 0; n_bad = 0;
        von_a = 1'bx; von_b = 1'bx; von_c = 1'bx; von_d = 1'bx; von_e = 1'bx;
        prev_vs = v_vs;
        for (int i = 1; i <= 3675; i++) begin
            step(1);
            if (!v_vs) begin
                n_low++;
                if (int'(v_row) < lo_min) lo_min = int'(v_row);
                if (int'(v_row) > lo_max) lo_max = int'(v_row);
            end
            if (v_vs != prev_vs && v_col != 10'd0) n_bad++;
            prev_vs = v_vs;
            if (v_fs) begin n_fs++; fs_at = i; end
            if (v_col == 10'd0 && v_row == 10'd479) von_a = v_von;
            if (v_col == 10'd0 && v_row == 10'd480) von_b = v_von;
            if (v_col == 10'd6 && v_row == 10'd524) von_c = v_von;
            if (v_col == 10'd3 && v_row == 10'd0)   von_d = v_von;
            if (v_col == 10'd4 && v_row == 10'd0)   von_e = v_von;
        end
        check("frame_vs_low",    32'(n_low),  14);
        check("frame_vs_first",  32'(lo_min), 490);
        check("frame_vs_last",   32'(lo_max), 491);
        check("frame_vs_offcol", 32'(n_bad),  0);
        check("frame_fs_count",  32'(n_fs),   1);
        check("frame_fs_period", 32'(fs_at),  3675);
        check("von_0_479",       32'(von_a),  1);
        check("von_0_480",       32'(von_b),  0);
        check("von_6_524",       32'(von_c),  0);
        check("von_3_0",         32'(von_d),  1);
        check("von_4_0",         32'(von_e),  0);

        // ---------------- Scenario 5b: reset at row 300, col 3 ----------------
        found = 1'b0;
        for (int i = 0; i < 3675 && !found; i++) begin
            step(1);
            if (v_row == 10'd300 && v_col == 10'd3) found = 1'b1;
        end
        check("vert_seek_300_3", 32'(found), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("vert_mid_hs",   32'(v_hs),   1);
        check("vert_mid_vs",   32'(v_vs),   1);
        check("vert_mid_col",  32'(v_col),  0);
        check("vert_mid_row",  32'(v_row),  0);
        check("vert_mid_von",  32'(v_von),  0);
        check("vert_mid_tick", 32'(v_tick), 0);
        check("vert_mid_fs",   32'(v_fs),   0);
        step(1);
        check("vert_re_fs",  32'(v_fs),  1);
        check("vert_re_col", 32'(v_col), 0);
        check("vert_re_row", 32'(v_row), 0);
        check("vert_re_von", 32'(v_von), 1);

        // ---------------- Scenario 6: tiny raster, active-high syncs ----------------
        rst = 1'b1;
        step(2);
        check("tiny_rst2_hs", 32'(t_hs), 0);
        check("tiny_rst2_vs", 32'(t_vs), 0);
        rst = 1'b0;
        step(1);
        check("tiny_start_fs",  32'(t_fs),  1);
        check("tiny_start_col", 32'(t_col), 0);
        check("tiny_start_row", 32'(t_row), 0);
        check("tiny_start_von", 32'(t_von), 1);
        n_hi_h = 0; n_hi_v = 0; n_fs = 0; fs_at = 0; n_bad = 0; n_wrap = 0;
        prev_col = t_col;
        for (int i = 1; i <= 42; i++) begin
            step(1);
            if (!t_tick) n_bad++;
            if (t_hs) begin n_hi_h++; if (t_col != 10'd5) n_bad++; end
            if (t_vs) begin n_hi_v++; if (t_row != 10'd4) n_bad++; end
            if (prev_col == 10'd6) begin
                if (t_col == 10'd0) n_wrap++;
                else n_bad++;
            end
            prev_col = t_col;
            if (t_fs) begin n_fs++; fs_at = i; end
        end
        check("tiny_hs_high",   32'(n_hi_h), 6);
        check("tiny_vs_high",   32'(n_hi_v), 7);
        check("tiny_col_wraps", 32'(n_wrap), 6);
        check("tiny_bad",       32'(n_bad),  0);
        check("tiny_fs_count",  32'(n_fs),   1);
        check("tiny_fs_period", 32'(fs_at),  42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
